// File: rtl/mpmc9_ch_arbiter.sv
// Eight-channel memory controller arbiter: round robin, optional channel-0 priority with starvation guard (MPMC9_ARB_PRIO_EN).
// Grant registered one cycle after sampling; held until done, then a one-cycle release turnaround.
module mpmc9_ch_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       idle,
    input  logic       done,
    output logic [3:0] ch,
    output logic [7:0] gnt,
    output logic       ch_valid
);

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    arb_state_t state_q, state_d;
    logic [3:0] ch_d;
    logic [7:0] gnt_d;
    logic       valid_d;
    logic [2:0] last_q, last_d;
    logic [7:0] rr_req;
    logic [2:0] rr_win, rr_idx, win;
    logic       rr_hit;

`ifdef MPMC9_ARB_PRIO_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;
    logic          starved;

    // Channel 0 has had its quota and someone else is waiting: exclude it this round.
    assign starved = (starve_q == CW'(STARVE_LIMIT)) && (|req[7:1]);
    assign rr_req  = starved ? {req[7:1], 1'b0} : req;
    assign win     = (req[0] && !starved) ? 3'd0 : rr_win;
`else
    assign rr_req  = req;
    assign win     = rr_win;
`endif

    // Search last+1 .. last+8 (wrapping), so the last winner has lowest priority.
    always_comb begin
        rr_win = last_q;
        rr_hit = 1'b0;
        rr_idx = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            rr_idx = last_q + 3'(i);
            if (!rr_hit && rr_req[rr_idx]) begin
                rr_win = rr_idx;
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch;
        gnt_d   = gnt;
        valid_d = ch_valid;
        last_d  = last_q;
`ifdef MPMC9_ARB_PRIO_EN
        starve_d = starve_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (idle && (|req)) begin
                    state_d = ARB_GRANT;
                    ch_d    = {1'b0, win};
                    gnt_d   = 8'd1 << win;
                    valid_d = 1'b1;
                    last_d  = win;
`ifdef MPMC9_ARB_PRIO_EN
                    if (win != 3'd0)
                        starve_d = '0;
                    else if ((|req[7:1]) && (starve_q != CW'(STARVE_LIMIT)))
                        starve_d = starve_q + 1'b1;
`endif
                end else begin
                    ch_d    = 4'hF;
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                end
            end
            ARB_GRANT: begin
                if (done) begin
                    state_d = ARB_RELEASE;
                    ch_d    = 4'hF;
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                ch_d    = 4'hF;
                gnt_d   = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ch       <= 4'hF;
            gnt      <= 8'h00;
            ch_valid <= 1'b0;
            last_q   <= 3'd7;
        end else begin
            state_q  <= state_d;
            ch       <= ch_d;
            gnt      <= gnt_d;
            ch_valid <= valid_d;
            last_q   <= last_d;
        end
    end

`ifdef MPMC9_ARB_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

endmodule

// File: tb/tb_mpmc9_ch_arbiter.sv
// Directed self-checking bench for mpmc9_ch_arbiter.
module tb_mpmc9_ch_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       idle;
    logic       done;
    logic [3:0] ch;
    logic [7:0] gnt;
    logic       ch_valid;

    int checks = 0;
    int errors = 0;

    mpmc9_ch_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .idle(idle), .done(done),
        .ch(ch), .gnt(gnt), .ch_valid(ch_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; idle = 1'b0; done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'h00; idle = 1'b0; done = 1'b0;
        #3;
        checks++;
        if (ch !== 4'hF || gnt !== 8'h00 || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ch=%h gnt=%h vld=%b want ch=f gnt=00 vld=0", ch, gnt, ch_valid);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_two_channel();
        do_reset();
        req = 8'h81; idle = 1'b1;
        step();
        checks++;
        if (ch !== 4'h0 || gnt !== 8'h01 || ch_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_grant ch=%h gnt=%h vld=%b want ch=0 gnt=01 vld=1", ch, gnt, ch_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (ch !== 4'hF || gnt !== 8'h00 || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_81 ch=%h gnt=%h vld=%b want ch=f gnt=00 vld=0", ch, gnt, ch_valid);
        end
        step();
        checks++;
        if (ch !== 4'hF) begin
            errors++;
            $display("FAIL turnaround_81 ch=%h want f", ch);
        end
        step();
        checks++;
        if (ch !== 4'h7 || gnt !== 8'h80 || ch_valid !== 1'b1) begin
            errors++;
            $display("FAIL second_grant ch=%h gnt=%h vld=%b want ch=7 gnt=80 vld=1", ch, gnt, ch_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ch;
        do_reset();
        req = 8'hFF; idle = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_ch = 4'(k % 8);
            step();
            checks++;
            if (ch !== exp_ch || gnt !== (8'd1 << exp_ch) || ch_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d] ch=%h gnt=%h vld=%b want ch=%h", k, ch, gnt, ch_valid, exp_ch);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            checks++;
            if (ch !== 4'hF || ch_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_release[%0d] ch=%h vld=%b want ch=f vld=0", k, ch, ch_valid);
            end
            step();
            checks++;
            if (ch !== 4'hF || gnt !== 8'h00) begin
                errors++;
                $display("FAIL rr_turnaround[%0d] ch=%h gnt=%h want ch=f gnt=00", k, ch, gnt);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_hold_until_done();
        do_reset();
        req = 8'h08; idle = 1'b1;
        step();
        req = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (ch !== 4'h3 || gnt !== 8'h08 || ch_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d] ch=%h gnt=%h vld=%b want ch=3 gnt=08 vld=1", k, ch, gnt, ch_valid);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (ch !== 4'hF || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release ch=%h vld=%b want ch=f vld=0", ch, ch_valid);
        end
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        checks++;
        if (ch !== 4'hF || gnt !== 8'h00 || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_regrant ch=%h gnt=%h vld=%b want ch=f gnt=00 vld=0", ch, gnt, ch_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h20; idle = 1'b1;
        step();
        checks++;
        if (ch !== 4'h5) begin
            errors++;
            $display("FAIL pre_reset_grant ch=%h want 5", ch);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ch !== 4'hF || gnt !== 8'h00 || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset ch=%h gnt=%h vld=%b want ch=f gnt=00 vld=0", ch, gnt, ch_valid);
        end
        #1 rst = 1'b0;
        step();
        checks++;
        if (ch !== 4'h5 || gnt !== 8'h20 || ch_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_grant ch=%h gnt=%h vld=%b want ch=5 gnt=20 vld=1", ch, gnt, ch_valid);
        end
    endtask

    task automatic test_idle_gate();
        do_reset();
        req = 8'h10; idle = 1'b0;
        step();
        step();
        checks++;
        if (ch !== 4'hF || gnt !== 8'h00 || ch_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_low ch=%h gnt=%h vld=%b want ch=f gnt=00 vld=0", ch, gnt, ch_valid);
        end
        idle = 1'b1;
        step();
        checks++;
        if (ch !== 4'h4 || gnt !== 8'h10 || ch_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_rise ch=%h gnt=%h vld=%b want ch=4 gnt=10 vld=1", ch, gnt, ch_valid);
        end
    endtask

    task automatic test_two_requesters();
        logic [3:0] exp_ch;
        do_reset();
        req = 8'h03; idle = 1'b1;
        for (int k = 0; k < 18; k++) begin
`ifdef MPMC9_ARB_PRIO_EN
            exp_ch = (k % 9 == 8) ? 4'h1 : 4'h0;
`else
            exp_ch = 4'(k % 2);
`endif
            step();
            checks++;
            if (ch !== exp_ch) begin
                errors++;
                $display("FAIL pair_grant[%0d] ch=%h want %h", k, ch, exp_ch);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
        req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_two_channel();
        test_round_robin();
        test_hold_until_done();
        test_reset_mid_grant();
        test_idle_gate();
        test_two_requesters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
